vx_branch_resolver: RTL and testbench



---
 rtl/vx_branch_resolver_pkg.sv | 17 +
 rtl/vx_branch_resolver_if.sv | 18 +
 rtl/vx_branch_resolver_rr_arb.sv | 40 ++++
 rtl/vx_branch_resolver.sv | 163 ++++++++++++++++
 tb/tb_vx_branch_resolver.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_branch_resolver_pkg.sv
// Shared types for the per-warp branch resolution tracker.
package vx_branch_resolver_pkg;

  localparam int BR_STATE_BITS = 2;

  typedef enum logic [BR_STATE_BITS-1:0] {
    BR_STATE_IDLE     = 2'd0,
    BR_STATE_WAIT     = 2'd1,
    BR_STATE_RESOLVED = 2'd2
  } br_state_e;

  // Index width that never collapses to zero for single-entry tables.
  function automatic int br_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_branch_resolver_if.sv
// Redirect channel from the branch resolver to fetch (valid/ready handshake).
interface vx_branch_resolver_if
  import vx_branch_resolver_pkg::*;
#(
  parameter int NW_WIDTH = 2,
  parameter int PC_BITS  = 30
);

  logic                valid;
  logic                ready;
  logic [NW_WIDTH-1:0] wid;
  logic                taken;
  logic [PC_BITS-1:0]  pc;

  modport master (output valid, wid, taken, pc, input ready);
  modport slave  (input valid, wid, taken, pc, output ready);

endinterface

// File: rtl/vx_branch_resolver_rr_arb.sv
// Round-robin arbiter; priority moves just past the winner whenever a grant is consumed.
module vx_branch_resolver_rr_arb
  import vx_branch_resolver_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int IDX_W    = br_idx_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQS);
      if (!grant_valid && requests[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (advance && grant_valid) begin
      ptr_q <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vx_branch_resolver.sv
// Per-warp branch tracker: stalls a warp at branch issue, captures the ALU outcome,
// and serialises resolutions to fetch through a registered redirect stage.
module vx_branch_resolver
  import vx_branch_resolver_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int NUM_SRCS  = 1,
  parameter  int PC_BITS   = 30,
  localparam int NW_WIDTH  = br_idx_width(NUM_WARPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic [NW_WIDTH-1:0]          issue_wid,
  input  logic [NUM_SRCS-1:0]          br_valid,
  input  logic [NUM_SRCS*NW_WIDTH-1:0] br_wid,
  input  logic [NUM_SRCS-1:0]          br_taken,
  input  logic [NUM_SRCS*PC_BITS-1:0]  br_dest,
  vx_branch_resolver_if.master         redirect,
  output logic [NUM_WARPS-1:0]         warp_stalled,
  output logic                         proto_err
);

  br_state_e           state_q [NUM_WARPS];
  br_state_e           state_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] warp_taken;
  logic [PC_BITS-1:0]   warp_dest [NUM_WARPS];
  logic [NUM_WARPS-1:0] err_issue, err_res, err_dup;
  logic [NUM_WARPS-1:0] req_p0;
  logic                 load_p0, gnt_vld_p0;
  logic [NW_WIDTH-1:0]  gnt_idx_p0;
  logic                 vld_p1, taken_p1;
  logic [NW_WIDTH-1:0]  wid_p1;
  logic [PC_BITS-1:0]   pc_p1;
  logic                 err_q;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    logic               hit, dup, sel_taken, cap;
    logic [PC_BITS-1:0] sel_dest;
    logic               accept_w, issue_w, e_iss;
    br_state_e          nxt;
    logic               taken_r;
    logic [PC_BITS-1:0] dest_r;

    // Lowest-index source claiming this warp wins; any further claimant is a violation.
    always_comb begin
      hit       = 1'b0;
      dup       = 1'b0;
      sel_taken = 1'b0;
      sel_dest  = '0;
      for (int j = 0; j < NUM_SRCS; j++) begin
        if (br_valid[j] && (br_wid[j*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w))) begin
          if (hit) begin
            dup = 1'b1;
          end else begin
            hit       = 1'b1;
            sel_taken = br_taken[j];
            sel_dest  = br_dest[j*PC_BITS +: PC_BITS];
          end
        end
      end
    end

    assign accept_w = vld_p1 && redirect.ready && (wid_p1 == NW_WIDTH'(w));
    assign issue_w  = issue_valid && (issue_wid == NW_WIDTH'(w));
    assign cap      = hit && (state_q[w] == BR_STATE_WAIT);

    // Acceptance retires the warp before a same-cycle issue re-arms it.
    always_comb begin
      nxt   = state_q[w];
      e_iss = 1'b0;
      case (state_q[w])
        BR_STATE_IDLE: begin
          if (issue_w) nxt = BR_STATE_WAIT;
        end
        BR_STATE_WAIT: begin
          if (hit) nxt = BR_STATE_RESOLVED;
          e_iss = issue_w;
        end
        BR_STATE_RESOLVED: begin
          if (accept_w) nxt = issue_w ? BR_STATE_WAIT : BR_STATE_IDLE;
          else          e_iss = issue_w;
        end
        default: nxt = BR_STATE_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (cap) begin
        taken_r <= sel_taken;
        dest_r  <= sel_dest;
      end
    end

    assign state_d[w]      = nxt;
    assign err_issue[w]    = e_iss;
    assign err_res[w]      = hit && (state_q[w] != BR_STATE_WAIT);
    assign err_dup[w]      = dup;
    assign warp_taken[w]   = taken_r;
    assign warp_dest[w]    = dest_r;
    assign warp_stalled[w] = (state_q[w] != BR_STATE_IDLE);
    assign req_p0[w]       = (state_q[w] == BR_STATE_RESOLVED) &&
                             !(vld_p1 && (wid_p1 == NW_WIDTH'(w)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) state_q[i] <= BR_STATE_IDLE;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) state_q[i] <= state_d[i];
    end
  end

  // ---- p0: arbitration over resolved warps not already held in the output stage
  assign load_p0 = !vld_p1 || redirect.ready;

  vx_branch_resolver_rr_arb #(
    .NUM_REQS (NUM_WARPS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .requests    (req_p0),
    .advance     (load_p0),
    .grant_valid (gnt_vld_p0),
    .grant_idx   (gnt_idx_p0)
  );

  // ---- p1: registered redirect stage presented to fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      wid_p1   <= '0;
      taken_p1 <= 1'b0;
      pc_p1    <= '0;
    end else if (load_p0) begin
      vld_p1 <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        wid_p1   <= gnt_idx_p0;
        taken_p1 <= warp_taken[gnt_idx_p0];
        pc_p1    <= warp_dest[gnt_idx_p0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | (|err_issue) | (|err_res) | (|err_dup);
  end

  assign redirect.valid = vld_p1;
  assign redirect.wid   = wid_p1;
  assign redirect.taken = taken_p1;
  assign redirect.pc    = pc_p1;
  assign proto_err      = err_q;

  a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
    (vld_p1 && !redirect.ready) |=>
      (vld_p1 && $stable(wid_p1) && $stable(pc_p1) && $stable(taken_p1)));

  a_held_is_resolved: assert property (@(posedge clk) disable iff (!reset)
    vld_p1 |-> (state_q[wid_p1] == BR_STATE_RESOLVED));

endmodule

// File: tb/tb_vx_branch_resolver.sv
// Directed bench for vx_branch_resolver with two branch-control sources.
module tb_vx_branch_resolver;

  localparam int NUM_WARPS = 4;
  localparam int NUM_SRCS  = 2;
  localparam int PC_BITS   = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [1:0]  issue_wid;
  logic [1:0]  br_valid;
  logic [3:0]  br_wid;
  logic [1:0]  br_taken;
  logic [59:0] br_dest;
  logic [3:0]  warp_stalled;
  logic        proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vx_branch_resolver_if #(.NW_WIDTH(2), .PC_BITS(PC_BITS)) rd_if ();

  vx_branch_resolver #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_SRCS  (NUM_SRCS),
    .PC_BITS   (PC_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_wid    (issue_wid),
    .br_valid     (br_valid),
    .br_wid       (br_wid),
    .br_taken     (br_taken),
    .br_dest      (br_dest),
    .redirect     (rd_if),
    .warp_stalled (warp_stalled),
    .proto_err    (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_redirect(input string tag, input int wid, input int tk, input int pc);
    check({tag, "_valid"}, 32'(rd_if.valid), 32'd1);
    check({tag, "_wid"},   32'(rd_if.wid),   32'(wid));
    check({tag, "_taken"}, 32'(rd_if.taken), 32'(tk));
    check({tag, "_pc"},    32'(rd_if.pc),    32'(pc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = '0;
    br_wid   = '0;
    br_taken = '0;
    br_dest  = '0;
  endtask

  task automatic set_br(input int src, input int wid, input int tk, input int dest);
    br_valid[src]            = 1'b1;
    br_wid[src*2 +: 2]       = 2'(wid);
    br_taken[src]            = 1'(tk);
    br_dest[src*30 +: 30]    = 30'(dest);
  endtask

  task automatic issue(input int wid);
    issue_valid = 1'b1;
    issue_wid   = 2'(wid);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic resolve1(input int src, input int wid, input int tk, input int dest);
    clear_br();
    set_br(src, wid, tk, dest);
    step();
    clear_br();
  endtask

  task automatic do_reset();
    issue_valid = 1'b0;
    clear_br();
    rd_if.ready = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    issue_valid = 1'b0;
    issue_wid   = '0;
    clear_br();
    rd_if.ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    check("rst_valid", 32'(rd_if.valid),  32'd0);
    check("rst_wid",   32'(rd_if.wid),    32'd0);
    check("rst_taken", 32'(rd_if.taken),  32'd0);
    check("rst_pc",    32'(rd_if.pc),     32'd0);
    check("rst_stall", 32'(warp_stalled), 32'd0);
    check("rst_perr",  32'(proto_err),    32'd0);

    // Basic taken branch: issue w2 at t0, resolve at t3, redirect at t5.
    issue(2);
    check("basic_t1_stall", 32'(warp_stalled), 32'b0100);
    step();
    step();
    resolve1(0, 2, 1, 'h100);
    check("basic_t4_novalid", 32'(rd_if.valid), 32'd0);
    step();
    check_redirect("basic_t5", 2, 1, 'h100);
    check("basic_t5_stall", 32'(warp_stalled), 32'b0100);
    step();
    check("basic_t6_stall", 32'(warp_stalled), 32'd0);
    check("basic_t6_valid", 32'(rd_if.valid),  32'd0);

    // Backpressure: fetch stalls for four cycles.
    rd_if.ready = 1'b0;
    issue(2);
    resolve1(0, 2, 1, 'h100);
    step();
    for (int i = 0; i < 4; i++) begin
      check_redirect("bp_hold", 2, 1, 'h100);
      check("bp_hold_stall", 32'(warp_stalled[2]), 32'd1);
      step();
    end
    rd_if.ready = 1'b1;
    step();
    check("bp_release_stall", 32'(warp_stalled), 32'd0);
    check("bp_release_valid", 32'(rd_if.valid),  32'd0);

    // Concurrent resolutions from both sources.
    do_reset();
    issue(0);
    issue(3);
    clear_br();
    set_br(0, 0, 0, 'h55);
    set_br(1, 3, 1, 'h2A0);
    step();
    clear_br();
    step();
    check("conc_first_valid", 32'(rd_if.valid), 32'd1);
    check("conc_first_wid",   32'(rd_if.wid),   32'd0);
    check("conc_first_taken", 32'(rd_if.taken), 32'd0);
    step();
    check_redirect("conc_second", 3, 1, 'h2A0);
    step();
    check("conc_done_valid", 32'(rd_if.valid),  32'd0);
    check("conc_done_stall", 32'(warp_stalled), 32'd0);
    check("conc_done_perr",  32'(proto_err),    32'd0);

    // Fairness: all four resolved, w0 re-issued and re-resolved mid-sequence.
    do_reset();
    rd_if.ready = 1'b0;
    for (int w = 0; w < 4; w++) issue(w);
    clear_br();
    set_br(0, 0, 1, 'h400);
    set_br(1, 1, 0, 'h0);
    step();
    clear_br();
    set_br(0, 2, 1, 'h222);
    set_br(1, 3, 1, 'h333);
    step();
    clear_br();
    check("fair_g0_wid",  32'(rd_if.wid),    32'd0);
    check("fair_g0_vld",  32'(rd_if.valid),  32'd1);
    check("fair_allstall", 32'(warp_stalled), 32'b1111);
    rd_if.ready = 1'b1;
    issue(0);
    check("fair_g1_wid", 32'(rd_if.wid), 32'd1);
    check("fair_reissue_perr", 32'(proto_err), 32'd0);
    resolve1(0, 0, 1, 'h3F0);
    check_redirect("fair_g2", 2, 1, 'h222);
    step();
    check_redirect("fair_g3", 3, 1, 'h333);
    step();
    check_redirect("fair_g4", 0, 1, 'h3F0);
    step();
    check("fair_done_valid", 32'(rd_if.valid),  32'd0);
    check("fair_done_stall", 32'(warp_stalled), 32'd0);
    check("fair_done_perr",  32'(proto_err),    32'd0);

    // Protocol errors: resolving an idle warp, double issue, duplicate sources.
    do_reset();
    resolve1(0, 1, 0, 'h11);
    check("err_idle_perr", 32'(proto_err), 32'd1);
    step();
    step();
    check("err_idle_noredir", 32'(rd_if.valid),  32'd0);
    check("err_idle_stall",   32'(warp_stalled), 32'd0);
    issue(1);
    check("err_iss1_stall", 32'(warp_stalled), 32'b0010);
    issue(1);
    check("err_iss2_stall", 32'(warp_stalled), 32'b0010);
    check("err_iss2_perr",  32'(proto_err),    32'd1);
    resolve1(0, 1, 1, 'h77);
    step();
    check_redirect("err_after", 1, 1, 'h77);

    do_reset();
    issue(2);
    clear_br();
    set_br(0, 2, 1, 'h10);
    set_br(1, 2, 0, 'h20);
    step();
    clear_br();
    check("dup_perr", 32'(proto_err), 32'd1);
    step();
    check_redirect("dup_low_wins", 2, 1, 'h10);

    // Reset mid-flight: w2 waiting, w3 held in the output stage.
    do_reset();
    rd_if.ready = 1'b0;
    issue(3);
    issue(2);
    resolve1(0, 3, 1, 'h123);
    step();
    check_redirect("mid_pre", 3, 1, 'h123);
    check("mid_pre_stall", 32'(warp_stalled), 32'b1100);
    #2;
    reset = 1'b0;
    #1;
    check("mid_async_valid", 32'(rd_if.valid),  32'd0);
    check("mid_async_wid",   32'(rd_if.wid),    32'd0);
    check("mid_async_taken", 32'(rd_if.taken),  32'd0);
    check("mid_async_pc",    32'(rd_if.pc),     32'd0);
    check("mid_async_stall", 32'(warp_stalled), 32'd0);
    check("mid_async_perr",  32'(proto_err),    32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    rd_if.ready = 1'b1;
    resolve1(0, 2, 0, 'h5);
    check("mid_late_res_perr", 32'(proto_err), 32'd1);
    step();
    step();
    check("mid_late_noredir", 32'(rd_if.valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
